i2c_cfg_seq: RTL

I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

---
 rtl/i2c_cfg_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/i2c_cfg_seq.sv
// Power-up register configuration sequencer: walks a table of {reg_addr, reg_val}
// words, issues one I2C write per entry, and treats reg_addr 16'hFFFF as a delay entry.
module i2c_cfg_seq #(
   parameter logic [7:0]  DEV_ADDR = 8'h78,
   parameter logic [9:0]  LUT_SIZE = 10'd256,
   parameter logic [15:0] PWR_DLY  = 16'd20000,
   parameter logic [6:0]  TO_CYC   = 7'd100
) (
   input  logic        clk_20k,
   input  logic        rst_100,
   input  logic        cfg_start,
   output logic [9:0]  rom_addr,
   input  logic [23:0] rom_data,
   output logic [31:0] cfg_data,
   output logic        i2c_req,
   input  logic        i2c_ack,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_err
);

   typedef enum logic [2:0] {
      S_PWR, S_LOAD, S_REQ, S_REL, S_GAP, S_DLY, S_DONE
   } state_t;

   localparam logic [15:0] PWR_LAST = PWR_DLY - 16'd1;
   localparam logic [15:0] TO_LAST  = 16'(TO_CYC) - 16'd1;
   localparam logic [9:0]  LUT_LAST = LUT_SIZE - 10'd1;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] dly_last_q, dly_last_d;
   logic [9:0]  addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        req_q, req_d;
   logic        err_q, err_d;
   logic        advance;

   always_ff @(posedge clk_20k or negedge rst_100) begin
      if (!rst_100) begin
         state_q    <= S_PWR;
         cnt_q      <= '0;
         dly_last_q <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         req_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dly_last_q <= dly_last_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         req_q      <= req_d;
         err_q      <= err_d;
      end
   end

   // One shared counter serves the power-up wait, ack timeout, gap and delay entries.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dly_last_d = dly_last_q;
      addr_d     = addr_q;
      data_d     = data_q;
      err_d      = err_q;
      advance    = 1'b0;
      case (state_q)
         S_PWR: begin
            if (cnt_q == PWR_LAST) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               addr_d  = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_LOAD: begin
            cnt_d = '0;
            if (rom_data[23:8] == 16'hFFFF) begin
               state_d    = S_DLY;
               dly_last_d = (rom_data[7:0] == 8'd0) ? 16'd0
                          : ({8'd0, rom_data[7:0]} * 16'd20) - 16'd1;
            end else begin
               state_d = S_REQ;
               data_d  = {DEV_ADDR, rom_data};
            end
         end
         S_REQ: begin
            if (i2c_ack) begin
               state_d = S_REL;
            end else if (cnt_q == TO_LAST) begin
               state_d = S_REL;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_REL: begin
            cnt_d = '0;
            if (!i2c_ack) state_d = S_GAP;
         end
         S_GAP: begin
            if (cnt_q == 16'd1) advance = 1'b1;
            else                cnt_d   = cnt_q + 16'd1;
         end
         S_DLY: begin
            if (cnt_q == dly_last_q) advance = 1'b1;
            else                     cnt_d   = cnt_q + 16'd1;
         end
         S_DONE: begin
            if (cfg_start) begin
               state_d = S_LOAD;
               addr_d  = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_PWR;
      endcase
      if (advance) begin
         cnt_d = '0;
         if (addr_q == LUT_LAST) begin
            state_d = S_DONE;
         end else begin
            state_d = S_LOAD;
            addr_d  = addr_q + 10'd1;
         end
      end
      // Registered request; LOAD always separates two REQ visits, so it cannot fall and rise together.
      req_d = (state_d == S_REQ);
   end

   always_comb begin
      cfg_busy = (state_q != S_DONE);
      cfg_done = (state_q == S_DONE);
      rom_addr = addr_q;
      cfg_data = data_q;
      i2c_req  = req_q;
      cfg_err  = err_q;
   end

endmodule
